// File: rtl/fft_butterfly_issue_ctrl.sv
// Radix-2 FFT stage issue controller: walks butterflies for one stage and retires write-backs in issue order.
// Optional macro FFT_ISSUE_PERF_CNT_EN adds the stall_cycles performance counter output.
module fft_butterfly_issue_ctrl #(
    parameter int LOG_N        = 10,
    parameter int BFLY_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stage_start,
    input  logic [$clog2(LOG_N)-1:0] stage_idx,
    input  logic                     issue_stall,
    output logic                     rd_en,
    output logic [LOG_N-1:0]         rd_addr_a,
    output logic [LOG_N-1:0]         rd_addr_b,
    output logic                     bfly_start,
    input  logic                     bfly_done,
    output logic                     wr_en,
    output logic [LOG_N-1:0]         wr_addr_a,
    output logic [LOG_N-1:0]         wr_addr_b,
    output logic                     busy,
    output logic                     stage_done,
`ifdef FFT_ISSUE_PERF_CNT_EN
    output logic [31:0]              stall_cycles,
`endif
    output logic                     err
);
    localparam int SW = $clog2(LOG_N);
    localparam logic [LOG_N-1:0] K_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [LOG_N-1:0]        k;
    logic [SW-1:0]           s_q;
    logic [BFLY_LATENCY-1:0] start_hist;
    logic [2*LOG_N-1:0]      fifo_mem [8];
    logic [2:0]              wptr;
    logic [2:0]              rptr;
    logic [3:0]              count;
    logic [3:0]              count_nxt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    issue;
    logic                    pop;
    logic                    in_flight;
    logic [LOG_N-1:0]        half;
    logic [LOG_N-1:0]        addr_a;
    logic [LOG_N-1:0]        addr_b;
    logic [2*LOG_N-1:0]      head;

    assign fifo_full  = (count == 4'd8);
    assign fifo_empty = (count == 4'd0);
    assign issue      = (state == ISSUE) && !issue_stall && !fifo_full;
    assign pop        = bfly_done && !fifo_empty;
    assign count_nxt  = count + 4'(issue) - 4'(pop);
    assign head       = fifo_mem[rptr];
    // Any start still within its latency window keeps the stage from closing.
    assign in_flight  = |start_hist;

    // Insert a zero at bit s of k: low s bits stay, the rest move up one place.
    always_comb begin
        half   = LOG_N'(1) << s_q;
        addr_a = (((k >> s_q) << s_q) << 1) | (k & (half - 1'b1));
        addr_b = addr_a | half;
    end

    assign rd_en      = issue;
    assign rd_addr_a  = issue ? addr_a : '0;
    assign rd_addr_b  = issue ? addr_b : '0;
    assign bfly_start = start_hist[0];
    assign wr_en      = pop;
    assign wr_addr_a  = pop ? head[2*LOG_N-1:LOG_N] : '0;
    assign wr_addr_b  = pop ? head[LOG_N-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            s_q        <= '0;
            busy       <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stage_start) begin
                        state <= ISSUE;
                        s_q   <= stage_idx;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if (k == K_LAST) state <= DRAIN;
                        else k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (count_nxt == 4'd0 && !in_flight) begin
                        state      <= DONE;
                        stage_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    stage_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_hist <= '0;
        else start_hist <= (start_hist << 1) | BFLY_LATENCY'(issue);
    end

    // Pending write-back FIFO; pointers wrap naturally at 8 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (issue) wptr <= wptr + 3'd1;
            if (pop) rptr <= rptr + 3'd1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) fifo_mem[wptr] <= {addr_a, addr_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (bfly_done && fifo_empty) err <= 1'b1;
    end

`ifdef FFT_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles <= '0;
        else if (state == IDLE && stage_start) stall_cycles <= '0;
        else if (state == ISSUE && !issue && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_butterfly_issue_ctrl.sv
// Directed bench for fft_butterfly_issue_ctrl: three instances cover address order, stalls and FIFO backpressure.
`timescale 1ns/1ps
module tb_fft_butterfly_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic ss3 = 0, st3 = 0, fd3 = 0;
    logic [1:0] si3 = '0;
    logic rd3, bs3, bd3, we3, busy3, sd3, err3;
    logic [2:0] ra3, rb3, wa3, wb3;
    logic [3:0] sr3;

    logic ss4 = 0, st4 = 0, fd4 = 0;
    logic [1:0] si4 = '0;
    logic rd4, bs4, bd4, we4, busy4, sd4, err4;
    logic [3:0] ra4, rb4, wa4, wb4;
    logic [3:0] sr4;

    logic ss5 = 0, st5 = 0, bd5 = 0;
    logic [2:0] si5 = '0;
    logic rd5, bs5, we5, busy5, sd5, err5;
    logic [4:0] ra5, rb5, wa5, wb5;

`ifdef FFT_ISSUE_PERF_CNT_EN
    logic [31:0] sc3, sc4, sc5;
`endif

    fft_butterfly_issue_ctrl #(.LOG_N(3), .BFLY_LATENCY(4)) dut3 (
        .clk(clk), .rst(rst), .stage_start(ss3), .stage_idx(si3), .issue_stall(st3),
        .rd_en(rd3), .rd_addr_a(ra3), .rd_addr_b(rb3), .bfly_start(bs3), .bfly_done(bd3),
        .wr_en(we3), .wr_addr_a(wa3), .wr_addr_b(wb3), .busy(busy3), .stage_done(sd3),
`ifdef FFT_ISSUE_PERF_CNT_EN
        .stall_cycles(sc3),
`endif
        .err(err3));

    fft_butterfly_issue_ctrl #(.LOG_N(4), .BFLY_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .stage_start(ss4), .stage_idx(si4), .issue_stall(st4),
        .rd_en(rd4), .rd_addr_a(ra4), .rd_addr_b(rb4), .bfly_start(bs4), .bfly_done(bd4),
        .wr_en(we4), .wr_addr_a(wa4), .wr_addr_b(wb4), .busy(busy4), .stage_done(sd4),
`ifdef FFT_ISSUE_PERF_CNT_EN
        .stall_cycles(sc4),
`endif
        .err(err4));

    fft_butterfly_issue_ctrl #(.LOG_N(5), .BFLY_LATENCY(6)) dut5 (
        .clk(clk), .rst(rst), .stage_start(ss5), .stage_idx(si5), .issue_stall(st5),
        .rd_en(rd5), .rd_addr_a(ra5), .rd_addr_b(rb5), .bfly_start(bs5), .bfly_done(bd5),
        .wr_en(we5), .wr_addr_a(wa5), .wr_addr_b(wb5), .busy(busy5), .stage_done(sd5),
`ifdef FFT_ISSUE_PERF_CNT_EN
        .stall_cycles(sc5),
`endif
        .err(err5));

    // Butterfly model for the 4-cycle instances: done follows start by exactly 4 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr3 <= '0;
            sr4 <= '0;
        end else begin
            sr3 <= {sr3[2:0], bs3};
            sr4 <= {sr4[2:0], bs4};
        end
    end
    assign bd3 = sr3[3] | fd3;
    assign bd4 = sr4[3] | fd4;

    function automatic bit rp4(int c);
        return (c >= 1 && c <= 10 && c != 3 && c != 4);
    endfunction

    function automatic bit rp5(int c);
        return (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        vecs++;
        if ({rd3, bs3, we3, busy3, sd3, err3, ra3, rb3, wa3, wb3} !== '0) begin
            errs++; $display("FAIL reset_async_dut3: got %b want 0", {rd3, bs3, we3, busy3, sd3, err3, ra3, rb3, wa3, wb3});
        end
        repeat (2) @(negedge clk);
        vecs++;
        if ({rd4, bs4, we4, busy4, sd4, err4, ra4, rb4, wa4, wb4} !== '0) begin
            errs++; $display("FAIL reset_dut4: got %b want 0", {rd4, bs4, we4, busy4, sd4, err4, ra4, rb4, wa4, wb4});
        end
        vecs++;
        if ({rd5, bs5, we5, busy5, sd5, err5, ra5, rb5, wa5, wb5} !== '0) begin
            errs++; $display("FAIL reset_dut5: got %b want 0", {rd5, bs5, we5, busy5, sd5, err5, ra5, rb5, wa5, wb5});
        end
`ifdef FFT_ISSUE_PERF_CNT_EN
        vecs++;
        if (sc4 !== 32'd0) begin errs++; $display("FAIL reset_stall_cycles: got %0d want 0", sc4); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_addr_gen();
        int ea [3][4];
        int eb [3][4];
        bit er, ew;
        ea = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
        eb = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            ss3 = 1'b1;
            si3 = 2'(s);
            for (int cyc = 1; cyc <= 12; cyc++) begin
                @(negedge clk);
                ss3 = 1'b0;
                #1;
                er = (cyc <= 4);
                ew = (cyc >= 6 && cyc <= 9);
                vecs++;
                if (rd3 !== er) begin errs++; $display("FAIL s%0d_rd_en cyc%0d: got %b want %b", s, cyc, rd3, er); end
                if (er) begin
                    vecs++;
                    if ({ra3, rb3} !== {3'(ea[s][cyc-1]), 3'(eb[s][cyc-1])}) begin
                        errs++; $display("FAIL s%0d_rd_addr cyc%0d: got (%0d,%0d) want (%0d,%0d)", s, cyc, ra3, rb3, ea[s][cyc-1], eb[s][cyc-1]);
                    end
                end
                vecs++;
                if (bs3 !== (cyc >= 2 && cyc <= 5)) begin errs++; $display("FAIL s%0d_bfly_start cyc%0d: got %b", s, cyc, bs3); end
                vecs++;
                if (we3 !== ew) begin errs++; $display("FAIL s%0d_wr_en cyc%0d: got %b want %b", s, cyc, we3, ew); end
                if (ew) begin
                    vecs++;
                    if ({wa3, wb3} !== {3'(ea[s][cyc-6]), 3'(eb[s][cyc-6])}) begin
                        errs++; $display("FAIL s%0d_wr_addr cyc%0d: got (%0d,%0d) want (%0d,%0d)", s, cyc, wa3, wb3, ea[s][cyc-6], eb[s][cyc-6]);
                    end
                end
                vecs++;
                if (sd3 !== (cyc == 10)) begin errs++; $display("FAIL s%0d_stage_done cyc%0d: got %b want %b", s, cyc, sd3, cyc == 10); end
                vecs++;
                if (busy3 !== (cyc <= 10)) begin errs++; $display("FAIL s%0d_busy cyc%0d: got %b want %b", s, cyc, busy3, cyc <= 10); end
            end
        end
        vecs++;
        if (err3 !== 1'b0) begin errs++; $display("FAIL addr_gen_err: got %b want 0", err3); end
    endtask

    task automatic test_stall();
        int ea [8];
        int eb [8];
        int ki, wi;
        bit er, ew;
        ea = '{0, 1, 4, 5, 8, 9, 12, 13};
        eb = '{2, 3, 6, 7, 10, 11, 14, 15};
        ki = 0;
        wi = 0;
        @(negedge clk);
        ss4 = 1'b1;
        si4 = 2'd1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            ss4 = 1'b0;
            st4 = (cyc == 3 || cyc == 4);
            #1;
            er = rp4(cyc);
            ew = rp4(cyc - 5);
            vecs++;
            if (rd4 !== er) begin errs++; $display("FAIL stall_rd_en cyc%0d: got %b want %b", cyc, rd4, er); end
            if (er) begin
                vecs++;
                if ({ra4, rb4} !== {4'(ea[ki]), 4'(eb[ki])}) begin
                    errs++; $display("FAIL stall_rd_addr k%0d: got (%0d,%0d) want (%0d,%0d)", ki, ra4, rb4, ea[ki], eb[ki]);
                end
                ki++;
            end
            vecs++;
            if (bs4 !== rp4(cyc - 1)) begin errs++; $display("FAIL stall_bfly_start cyc%0d: got %b want %b", cyc, bs4, rp4(cyc - 1)); end
            vecs++;
            if (we4 !== ew) begin errs++; $display("FAIL stall_wr_en cyc%0d: got %b want %b", cyc, we4, ew); end
            if (ew) begin
                vecs++;
                if ({wa4, wb4} !== {4'(ea[wi]), 4'(eb[wi])}) begin
                    errs++; $display("FAIL stall_wr_addr w%0d: got (%0d,%0d) want (%0d,%0d)", wi, wa4, wb4, ea[wi], eb[wi]);
                end
                wi++;
            end
            vecs++;
            if (sd4 !== (cyc == 16)) begin errs++; $display("FAIL stall_stage_done cyc%0d: got %b want %b", cyc, sd4, cyc == 16); end
        end
        st4 = 1'b0;
`ifdef FFT_ISSUE_PERF_CNT_EN
        vecs++;
        if (sc4 !== 32'd2) begin errs++; $display("FAIL stall_cycles_count: got %0d want 2", sc4); end
`endif
    endtask

    task automatic test_fifo_full();
        int ek, w;
        bit er, ew;
        @(negedge clk);
        ss5 = 1'b1;
        si5 = 3'd0;
        for (int cyc = 1; cyc <= 29; cyc++) begin
            @(negedge clk);
            ss5 = 1'b0;
            bd5 = (cyc >= 11 && cyc <= 26);
            #1;
            er = rp5(cyc);
            ek = (cyc <= 8) ? cyc - 1 : cyc - 4;
            ew = (cyc >= 11 && cyc <= 26);
            w = cyc - 11;
            vecs++;
            if (rd5 !== er) begin errs++; $display("FAIL full_rd_en cyc%0d: got %b want %b", cyc, rd5, er); end
            if (er) begin
                vecs++;
                if ({ra5, rb5} !== {5'(2 * ek), 5'(2 * ek + 1)}) begin
                    errs++; $display("FAIL full_rd_addr k%0d: got (%0d,%0d) want (%0d,%0d)", ek, ra5, rb5, 2 * ek, 2 * ek + 1);
                end
            end
            vecs++;
            if (bs5 !== rp5(cyc - 1)) begin errs++; $display("FAIL full_bfly_start cyc%0d: got %b want %b", cyc, bs5, rp5(cyc - 1)); end
            vecs++;
            if (we5 !== ew) begin errs++; $display("FAIL full_wr_en cyc%0d: got %b want %b", cyc, we5, ew); end
            if (ew) begin
                vecs++;
                if ({wa5, wb5} !== {5'(2 * w), 5'(2 * w + 1)}) begin
                    errs++; $display("FAIL full_wr_addr w%0d: got (%0d,%0d) want (%0d,%0d)", w, wa5, wb5, 2 * w, 2 * w + 1);
                end
            end
            vecs++;
            if (sd5 !== (cyc == 27)) begin errs++; $display("FAIL full_stage_done cyc%0d: got %b want %b", cyc, sd5, cyc == 27); end
            vecs++;
            if (busy5 !== (cyc <= 27)) begin errs++; $display("FAIL full_busy cyc%0d: got %b want %b", cyc, busy5, cyc <= 27); end
        end
        bd5 = 1'b0;
        vecs++;
        if (err5 !== 1'b0) begin errs++; $display("FAIL full_err: got %b want 0", err5); end
`ifdef FFT_ISSUE_PERF_CNT_EN
        vecs++;
        if (sc5 !== 32'd3) begin errs++; $display("FAIL full_stall_cycles: got %0d want 3", sc5); end
`endif
    endtask

    task automatic test_err_idle();
        @(negedge clk);
        fd3 = 1'b1;
        #1;
        vecs++;
        if (we3 !== 1'b0) begin errs++; $display("FAIL idle_done_wr_en: got %b want 0", we3); end
        vecs++;
        if ({wa3, wb3} !== 6'd0) begin errs++; $display("FAIL idle_done_wr_addr: got %b want 0", {wa3, wb3}); end
        @(negedge clk);
        fd3 = 1'b0;
        #1;
        vecs++;
        if (err3 !== 1'b1) begin errs++; $display("FAIL idle_done_err: got %b want 1", err3); end
        repeat (3) @(negedge clk);
        #1;
        vecs++;
        if (err3 !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b want 1", err3); end
        vecs++;
        if (busy3 !== 1'b0) begin errs++; $display("FAIL idle_done_busy: got %b want 0", busy3); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ss4 = 1'b1;
        si4 = 2'd0;
        @(negedge clk);
        ss4 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if (rd4 !== 1'b1) begin errs++; $display("FAIL mid_issue_rd_en: got %b want 1", rd4); end
        rst = 1'b1;
        #1;
        vecs++;
        if ({rd4, bs4, we4, busy4, sd4, ra4, rb4, wa4, wb4} !== '0) begin
            errs++; $display("FAIL mid_reset_outputs: got %b want 0", {rd4, bs4, we4, busy4, sd4, ra4, rb4, wa4, wb4});
        end
        vecs++;
        if (err3 !== 1'b0) begin errs++; $display("FAIL mid_reset_err_clear: got %b want 0", err3); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if (busy4 !== 1'b0) begin errs++; $display("FAIL post_reset_busy: got %b want 0", busy4); end
    endtask

    task automatic test_back_to_back();
        bit er, ew;
        @(negedge clk);
        ss4 = 1'b1;
        si4 = 2'd3;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            ss4 = 1'b0;
            #1;
            er = (cyc <= 8);
            ew = (cyc >= 6 && cyc <= 13);
            vecs++;
            if (rd4 !== er) begin errs++; $display("FAIL restart_rd_en cyc%0d: got %b want %b", cyc, rd4, er); end
            if (er) begin
                vecs++;
                if ({ra4, rb4} !== {4'(cyc - 1), 4'(cyc + 7)}) begin
                    errs++; $display("FAIL restart_rd_addr cyc%0d: got (%0d,%0d) want (%0d,%0d)", cyc, ra4, rb4, cyc - 1, cyc + 7);
                end
            end
            vecs++;
            if (we4 !== ew) begin errs++; $display("FAIL restart_wr_en cyc%0d: got %b want %b", cyc, we4, ew); end
            if (ew) begin
                vecs++;
                if ({wa4, wb4} !== {4'(cyc - 6), 4'(cyc + 2)}) begin
                    errs++; $display("FAIL restart_wr_addr cyc%0d: got (%0d,%0d) want (%0d,%0d)", cyc, wa4, wb4, cyc - 6, cyc + 2);
                end
            end
            vecs++;
            if (sd4 !== (cyc == 14)) begin errs++; $display("FAIL restart_stage_done cyc%0d: got %b want %b", cyc, sd4, cyc == 14); end
        end
        vecs++;
        if (err4 !== 1'b0) begin errs++; $display("FAIL restart_err: got %b want 0", err4); end
`ifdef FFT_ISSUE_PERF_CNT_EN
        vecs++;
        if (sc4 !== 32'd0) begin errs++; $display("FAIL restart_stall_cycles: got %0d want 0", sc4); end
`endif
        @(negedge clk);
        fd4 = 1'b1;
        #1;
        vecs++;
        if (we4 !== 1'b0) begin errs++; $display("FAIL empty_done_wr_en: got %b want 0", we4); end
        @(negedge clk);
        fd4 = 1'b0;
        #1;
        vecs++;
        if (err4 !== 1'b1) begin errs++; $display("FAIL empty_done_err: got %b want 1", err4); end
    endtask

    initial begin
        test_reset();
        test_addr_gen();
        test_stall();
        test_fifo_full();
        test_err_idle();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
